regfile_param: RTL

Parametrised register file: NREGS x WIDTH storage, one synchronous write port, two read ports built from a parametrised word-mux tree.
Generalises the fixed 16:1 bit-mux tree to arbitrary register count and word width.
Adds a hard-wired zero register, an optional registered-read stage and an optional write-to-read bypass.
Sits in the datapath decode stage, feeding ALU operands.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_mux_n_1.sv | 27 ++
 rtl/regfile_param.sv | 57 +++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address-width helper for the register file
package regfile_pkg;
    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_NREGS = 32;
    localparam int DEFAULT_ZERO_REG = 31;
    typedef logic [DEFAULT_WIDTH-1:0] word_t;
    function automatic int addr_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/regfile_mux_n_1.sv
// mux_n_1: recursive binary tree of 2:1 word muxes; selects >= N return 0
module mux_n_1 import regfile_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N = 2,
    localparam int SW = addr_w(N)
) (
    input  logic [N-1:0][WIDTH-1:0] din,
    input  logic [SW-1:0]           sel,
    output logic [WIDTH-1:0]        dout
);
    generate
        if (N == 1) begin : g_leaf
            assign dout = (sel == '0) ? din[0] : '0;
        end else if (N == 2) begin : g_pair
            assign dout = sel[0] ? din[1] : din[0];
        end else begin : g_node
            // lower subtree is the largest power of two below N, so low sel bits index both halves
            localparam int L = 1 << (SW - 1);
            localparam int LW = addr_w(L);
            localparam int HW = addr_w(N - L);
            logic [WIDTH-1:0] lo, hi;
            mux_n_1 #(.WIDTH(WIDTH), .N(L)) u_lo (.din(din[L-1:0]), .sel(sel[LW-1:0]), .dout(lo));
            mux_n_1 #(.WIDTH(WIDTH), .N(N-L)) u_hi (.din(din[N-1:L]), .sel(sel[HW-1:0]), .dout(hi));
            assign dout = ({1'b0, sel} < (SW+1)'(N)) ? (sel[SW-1] ? hi : lo) : '0;
        end
    endgenerate
endmodule

// File: rtl/regfile_param.sv
// regfile_param: NREGS x WIDTH register file, zero register, optional read register; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_param import regfile_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREGS = DEFAULT_NREGS,
    parameter int ZERO_REG = DEFAULT_ZERO_REG,
    parameter int READ_LATENCY = 0,
    localparam int AW = addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reg_write,
    input  logic [AW-1:0]    write_reg,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_reg1,
    input  logic [AW-1:0]    read_reg2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2
);
    localparam bit ZEN = ZERO_REG < NREGS;
    localparam int ZI = ZEN ? ZERO_REG : 0;
    localparam logic [AW-1:0] ZR = AW'(ZI);
    logic [NREGS-1:0][WIDTH-1:0] regs, view;
    logic [WIDTH-1:0] m1, m2, d1, d2;
    logic wr_ok;
    assign wr_ok = reg_write && !reset && ({1'b0, write_reg} < (AW+1)'(NREGS)) && !(ZEN && write_reg == ZR);
    always_ff @(posedge clk)
        if (reset) regs <= '0;
        else if (wr_ok) regs[write_reg] <= write_data;
    always_comb begin
        view = regs;
        view[ZI] = ZEN ? '0 : regs[ZI];
    end
    mux_n_1 #(.WIDTH(WIDTH), .N(NREGS)) u_mux1 (.din(view), .sel(read_reg1), .dout(m1));
    mux_n_1 #(.WIDTH(WIDTH), .N(NREGS)) u_mux2 (.din(view), .sel(read_reg2), .dout(m2));
`ifdef REGFILE_BYPASS_EN
    assign d1 = (wr_ok && write_reg == read_reg1) ? write_data : m1;
    assign d2 = (wr_ok && write_reg == read_reg2) ? write_data : m2;
`else
    assign d1 = m1;
    assign d2 = m2;
`endif
    generate
        if (READ_LATENCY == 1) begin : g_reg
            always_ff @(posedge clk)
                if (reset) begin
                    read_data1 <= '0;
                    read_data2 <= '0;
                end else begin
                    read_data1 <= d1;
                    read_data2 <= d2;
                end
        end else begin : g_comb
            assign read_data1 = d1;
            assign read_data2 = d2;
        end
    endgenerate
endmodule
